// File: rtl/rv_lsu_sb.sv
// Load/store unit for the Q103H memory-access stage: posted store buffer, in-order
// single outstanding load over a valid/ready memory port, lane alignment and extension.
module rv_lsu_sb #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int SB_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid_Q103H,
    input  logic                          req_wr_en_Q103H,
    input  logic                          req_rd_en_Q103H,
    input  logic [ADDR_W-1:0]             req_addr_Q103H,
    input  logic [DATA_W-1:0]             req_wr_data_Q103H,
    input  logic [1:0]                    req_size_Q103H,
    input  logic                          req_sign_ext_Q103H,
    output logic                          stall_Q103H,
    output logic                          ld_data_valid_Q103H,
    output logic [DATA_W-1:0]             ld_data_Q103H,
    output logic                          misalign_err_Q103H,
    output logic [$clog2(SB_DEPTH+1)-1:0] sb_count,
    output logic                          mem_req_valid,
    input  logic                          mem_req_ready,
    output logic [ADDR_W-1:0]             mem_req_addr,
    output logic                          mem_req_wr_en,
    output logic                          mem_req_rd_en,
    output logic [DATA_W/8-1:0]           mem_req_byte_en,
    output logic [DATA_W-1:0]             mem_req_wr_data,
    input  logic                          mem_rsp_valid,
    input  logic [DATA_W-1:0]             mem_rsp_data
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int PTR_W = $clog2(SB_DEPTH);
    localparam int CNT_W = $clog2(SB_DEPTH + 1);

    typedef enum logic [2:0] {IDLE, DRAIN, LD_REQ, LD_WAIT, DONE} state_t;

    function automatic logic [NB-1:0] lane_en(input logic [1:0] size, input logic [OFF_W-1:0] off);
        logic [15:0] ones;
        logic [15:0] sh;
        ones = (16'd1 << (5'd1 << size)) - 16'd1;
        sh   = ones << off;
        return sh[NB-1:0];
    endfunction

    function automatic logic [DATA_W-1:0] load_ext(input logic [DATA_W-1:0] raw,
                                                   input logic [OFF_W-1:0]  off,
                                                   input logic [1:0]        size,
                                                   input logic              sext);
        logic [DATA_W-1:0] d;
        logic [DATA_W-1:0] r;
        logic              msb;
        int                nbits;
        d     = raw >> {off, 3'b000};
        nbits = 8 << size;
        case (size)
            2'd0:    msb = d[7];
            2'd1:    msb = d[15];
            2'd2:    msb = d[31];
            default: msb = d[DATA_W-1];
        endcase
        for (int i = 0; i < DATA_W; i++)
            r[i] = (i < nbits) ? d[i] : (sext & msb);
        return r;
    endfunction

    state_t                   state, state_n;
    logic [ADDR_W-1:0]        sb_addr [SB_DEPTH];
    logic [NB-1:0]            sb_be   [SB_DEPTH];
    logic [DATA_W-1:0]        sb_data [SB_DEPTH];
    logic [PTR_W-1:0]         head, tail;
    logic [CNT_W-1:0]         count;
    logic [ADDR_W-1:0]        ld_addr;
    logic [1:0]               ld_size;
    logic                     ld_sext;
    logic [DATA_W-1:0]        ld_data_q;

    logic [OFF_W-1:0]         req_off;
    logic [3:0]               size_mask;
    logic                     req_mis, is_store, is_load;
    logic                     sb_full, sb_empty, deq, enq, ld_capture;

    assign req_off   = req_addr_Q103H[OFF_W-1:0];
    assign size_mask = (4'd1 << req_size_Q103H) - 4'd1;
    assign req_mis   = req_valid_Q103H & (req_wr_en_Q103H | req_rd_en_Q103H) &
                       ((|(4'(req_off) & size_mask)) | (req_size_Q103H == 2'd3 && DATA_W == 32));
    assign is_store  = req_valid_Q103H & req_wr_en_Q103H & ~req_mis;
    assign is_load   = req_valid_Q103H & req_rd_en_Q103H & ~req_mis;

    assign sb_full   = (count == CNT_W'(SB_DEPTH));
    assign sb_empty  = (count == '0);
    // The buffer head owns the port except while the load request is on it.
    assign deq       = ~sb_empty & (state != LD_REQ) & mem_req_ready;
    assign enq       = is_store & (state == IDLE) & (~sb_full | deq);

    assign misalign_err_Q103H = req_mis;
    assign ld_data_Q103H      = (state == DONE) ? ld_data_q : '0;
    assign sb_count           = count;

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        state_n             = state;
        stall_Q103H         = 1'b0;
        ld_data_valid_Q103H = 1'b0;
        ld_capture          = 1'b0;
        case (state)
            IDLE: begin
                if (is_load) begin
                    stall_Q103H = 1'b1;
                    ld_capture  = 1'b1;
                    state_n     = sb_empty ? LD_REQ : DRAIN;
                end else if (is_store && !enq) begin
                    stall_Q103H = 1'b1;
                end
            end
            DRAIN: begin
                stall_Q103H = 1'b1;
                if (sb_empty) state_n = LD_REQ;
            end
            LD_REQ: begin
                stall_Q103H = 1'b1;
                if (mem_req_ready) state_n = LD_WAIT;
            end
            LD_WAIT: begin
                stall_Q103H = 1'b1;
                if (mem_rsp_valid) state_n = DONE;
            end
            DONE: begin
                ld_data_valid_Q103H = 1'b1;
                state_n             = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        mem_req_valid   = 1'b0;
        mem_req_wr_en   = 1'b0;
        mem_req_rd_en   = 1'b0;
        mem_req_addr    = '0;
        mem_req_byte_en = '0;
        mem_req_wr_data = '0;
        if (state == LD_REQ) begin
            mem_req_valid   = 1'b1;
            mem_req_rd_en   = 1'b1;
            mem_req_addr    = {ld_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            mem_req_byte_en = lane_en(ld_size, ld_addr[OFF_W-1:0]);
        end else if (!sb_empty) begin
            mem_req_valid   = 1'b1;
            mem_req_wr_en   = 1'b1;
            mem_req_addr    = sb_addr[head];
            mem_req_byte_en = sb_be[head];
            mem_req_wr_data = sb_data[head];
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            ld_addr   <= '0;
            ld_size   <= '0;
            ld_sext   <= 1'b0;
            ld_data_q <= '0;
        end else begin
            state <= state_n;
            if (enq) tail <= tail + PTR_W'(1);
            if (deq) head <= head + PTR_W'(1);
            if (enq && !deq)      count <= count + CNT_W'(1);
            else if (!enq && deq) count <= count - CNT_W'(1);
            if (ld_capture) begin
                ld_addr <= req_addr_Q103H;
                ld_size <= req_size_Q103H;
                ld_sext <= req_sign_ext_Q103H;
            end
            if (state == LD_WAIT && mem_rsp_valid)
                ld_data_q <= load_ext(mem_rsp_data, ld_addr[OFF_W-1:0], ld_size, ld_sext);
        end
    end

    // NOTE: the entry storage has no reset; an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (enq) begin
            sb_addr[tail] <= {req_addr_Q103H[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
            sb_be[tail]   <= lane_en(req_size_Q103H, req_off);
            sb_data[tail] <= req_wr_data_Q103H << {req_off, 3'b000};
        end
    end
endmodule
